// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, oversampling constants and helpers.
// Kept separate so the transmit side can reuse the same encodings.
package uart_rx_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_W        = 4;
    localparam int unsigned DIV_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bit value is voted from samples 7/8/9; a bit period ends at index 15.
    localparam logic [SAMPLE_W-1:0] MAJ_IDX_LO  = SAMPLE_W'(7);
    localparam logic [SAMPLE_W-1:0] MAJ_IDX_MID = SAMPLE_W'(8);
    localparam logic [SAMPLE_W-1:0] MAJ_IDX_HI  = SAMPLE_W'(9);
    localparam logic [SAMPLE_W-1:0] BIT_END_IDX = SAMPLE_W'(UART_OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: latches the baud divisor on restart and pulses tick_c
// once every div clocks (div = 0 is treated as 1).
module uart_baud_gen
    import uart_rx_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             tick_c
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_c = (cnt_q == div_q - DIV_W'(1));

    // Restart wins over a coincident tick so a new frame always starts from count 0.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q + DIV_W'(1);
        if (restart_i) begin
            div_d = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
            cnt_d = '0;
        end else if (tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= DIV_W'(1);
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, 16x oversampled majority-vote deframer for
// 8N1 (optionally even-parity) characters, delivering a one-cycle strobe per frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [DIV_W-1:0]      baud_div_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  busy_o
);

    localparam int unsigned         BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [SAMPLE_W-1:0] LAST_IDX  = SAMPLE_W'(OVERSAMPLE - 1);

    logic sync1_q, sync2_q, prev_q;

    uart_state_e             state_q, state_d;
    logic [SAMPLE_W-1:0]     sample_q, sample_d;
    logic                    s_lo_q, s_lo_d;
    logic                    s_mid_q, s_mid_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    perr_pend_q, perr_pend_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    perr_q, perr_d;
    logic                    busy_q, busy_d;

    logic fall_c;
    logic restart_c;
    logic tick_c;
    logic bit_c;
    logic at_maj_c;
    logic at_end_c;

    // Both synchroniser flops and the edge-history flop idle high like the line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_c    = prev_q & ~sync2_q;
    assign restart_c = en_i & (state_q == ST_IDLE) & fall_c;
    assign bit_c     = majority3(s_lo_q, s_mid_q, sync2_q);
    assign at_maj_c  = tick_c & (sample_q == MAJ_IDX_HI);
    assign at_end_c  = tick_c & (sample_q == LAST_IDX);

    uart_baud_gen u_baud_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .restart_i  (restart_c),
        .baud_div_i (baud_div_i),
        .tick_c     (tick_c)
    );

    // Next-state and output logic; the stop bit is judged mid-bit so frames can abut.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        s_lo_d      = s_lo_q;
        s_mid_d     = s_mid_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        perr_pend_d = perr_pend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        perr_d      = 1'b0;

        if (!en_i) begin
            state_d  = ST_IDLE;
            sample_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (fall_c) begin
                state_d     = ST_START;
                sample_d    = '0;
                bit_cnt_d   = '0;
                perr_pend_d = 1'b0;
            end
        end else if (tick_c) begin
            sample_d = (sample_q == LAST_IDX) ? '0 : sample_q + SAMPLE_W'(1);
            if (sample_q == MAJ_IDX_LO) begin
                s_lo_d = sync2_q;
            end
            if (sample_q == MAJ_IDX_MID) begin
                s_mid_d = sync2_q;
            end

            case (state_q)
                ST_START: begin
                    if (at_maj_c && bit_c) begin
                        state_d = ST_IDLE;
                    end else if (at_end_c) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (at_maj_c) begin
                        shift_d   = {bit_c, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                    if (at_end_c && (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH))) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (at_maj_c) begin
                        perr_pend_d = (^shift_q) ^ bit_c;
                    end
                    if (at_end_c) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (at_maj_c) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = ~bit_c;
                        perr_d  = (PARITY_EN != 0) && perr_pend_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            s_lo_q      <= 1'b0;
            s_mid_q     <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            perr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            s_lo_q      <= s_lo_d;
            s_mid_q     <= s_mid_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            perr_pend_q <= perr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            busy_q      <= busy_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign busy_o       = busy_q;

endmodule
